// File: rtl/i2c_config_sequencer_if.sv
// Bus between the configuration sequencer and the I2C write controller.
// The controller's ready flag lives in the slow I2C clock domain.
interface i2c_config_sequencer_if;
  logic       i2c_start;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_data;
  logic       i2c_ready;

  modport master (
    output i2c_start,
    output i2c_dev_addr,
    output i2c_reg_addr,
    output i2c_data,
    input  i2c_ready
  );

  modport slave (
    input  i2c_start,
    input  i2c_dev_addr,
    input  i2c_reg_addr,
    input  i2c_data,
    output i2c_ready
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks an external register-write table and hands each entry to the I2C
// write controller, holding start until the controller drops ready.
module i2c_config_sequencer #(
  parameter int          NUM_WRITES     = 8,
  parameter int          IDX_W          = 4,
  parameter logic [6:0]  DEV_ADDR       = 7'h1A,
  parameter logic [15:0] GAP_CYCLES     = 16'd500,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   go,
  output logic [IDX_W-1:0]       tbl_index,
  input  logic [7:0]             tbl_reg,
  input  logic [7:0]             tbl_data,
  i2c_config_sequencer_if.master i2c,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             cur_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    WAIT_RDY    = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_DONE   = 3'd4,
    GAP         = 3'd5,
    DONE        = 3'd6,
    ERR         = 3'd7
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [7:0]       reg_q, reg_n, data_q, data_n;
  logic             start_q, start_n, done_n, error_n, busy_n;
  logic [23:0]      tmo_cnt, tmo_n;
  logic [15:0]      gap_cnt, gap_n;
  logic             rdy_meta, rdy_s;
  logic             timeout;

  assign i2c.i2c_start    = start_q;
  assign i2c.i2c_dev_addr = DEV_ADDR;
  assign i2c.i2c_reg_addr = reg_q;
  assign i2c.i2c_data     = data_q;
  assign cur_state        = state;

  // ready crosses in from the I2C clock domain
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= i2c.i2c_ready;
      rdy_s    <= rdy_meta;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      tbl_index <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      tbl_index <= idx_n;
      reg_q     <= reg_n;
      data_q    <= data_n;
      start_q   <= start_n;
      done      <= done_n;
      error     <= error_n;
      busy      <= busy_n;
      tmo_cnt   <= tmo_n;
      gap_cnt   <= gap_n;
    end
  end

  assign timeout = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    state_n = state;
    idx_n   = tbl_index;
    reg_n   = reg_q;
    data_n  = data_q;
    start_n = start_q;
    done_n  = done;
    error_n = error;
    tmo_n   = tmo_cnt;
    gap_n   = gap_cnt;

    case (state)
      IDLE, DONE, ERR: begin
        if (go) begin
          done_n  = 1'b0;
          error_n = 1'b0;
          idx_n   = '0;
          if (NUM_WRITES == 0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        reg_n   = tbl_reg;
        data_n  = tbl_data;
        tmo_n   = '0;
        state_n = WAIT_RDY;
      end
      WAIT_RDY, WAIT_ACCEPT, WAIT_DONE: begin
        // a timeout wins over a same-cycle ready change
        if (timeout) begin
          start_n = 1'b0;
          error_n = 1'b1;
          state_n = ERR;
        end else if (state == WAIT_RDY && rdy_s) begin
          start_n = 1'b1;
          tmo_n   = '0;
          state_n = WAIT_ACCEPT;
        end else if (state == WAIT_ACCEPT && !rdy_s) begin
          start_n = 1'b0;
          tmo_n   = '0;
          state_n = WAIT_DONE;
        end else if (state == WAIT_DONE && rdy_s) begin
          gap_n   = GAP_CYCLES;
          state_n = GAP;
        end else begin
          tmo_n = tmo_cnt + 24'd1;
        end
      end
      GAP: begin
        if (gap_cnt == 16'd0) begin
          if (tbl_index == LAST_IDX) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n   = tbl_index + 1'b1;
            state_n = LOAD;
          end
        end else begin
          gap_n = gap_cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = !(state_n == IDLE || state_n == DONE || state_n == ERR);
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench: a 3-entry sequencer against a behavioural controller model,
// plus an empty-table instance.
module tb_i2c_config_sequencer;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       go_a, go_b;
  logic [3:0] tbl_index_a, tbl_index_b;
  logic [7:0] tbl_reg_a, tbl_data_a;
  logic       busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [2:0] cur_state_a, cur_state_b;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  i2c_config_sequencer_if bus_a ();
  i2c_config_sequencer_if bus_b ();

  always #5 clk_in = ~clk_in;

  i2c_config_sequencer #(
    .NUM_WRITES(3), .IDX_W(4), .DEV_ADDR(7'h1A),
    .GAP_CYCLES(16'd4), .TIMEOUT_CYCLES(24'd100)
  ) dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .go(go_a),
    .tbl_index(tbl_index_a), .tbl_reg(tbl_reg_a), .tbl_data(tbl_data_a),
    .i2c(bus_a), .busy(busy_a), .done(done_a), .error(error_a),
    .cur_state(cur_state_a)
  );

  i2c_config_sequencer #(
    .NUM_WRITES(0), .IDX_W(4), .DEV_ADDR(7'h1A),
    .GAP_CYCLES(16'd4), .TIMEOUT_CYCLES(24'd100)
  ) dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .go(go_b),
    .tbl_index(tbl_index_b), .tbl_reg(8'h00), .tbl_data(8'h00),
    .i2c(bus_b), .busy(busy_b), .done(done_b), .error(error_b),
    .cur_state(cur_state_b)
  );

  assign bus_b.i2c_ready = 1'b1;

  always_comb begin
    case (tbl_index_a)
      4'd0:    begin tbl_reg_a = 8'h10; tbl_data_a = 8'hA5; end
      4'd1:    begin tbl_reg_a = 8'h11; tbl_data_a = 8'h5A; end
      4'd2:    begin tbl_reg_a = 8'h12; tbl_data_a = 8'hFF; end
      default: begin tbl_reg_a = 8'hEE; tbl_data_a = 8'hEE; end
    endcase
  end

  // Controller model: mode 0 drops ready ~7 cycles after start then raises it
  // 40 cycles later; mode 1 holds ready low; mode 2 never drops it.
  logic [1:0] phase;
  logic [7:0] cnt;
  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bus_a.i2c_ready <= 1'b1;
      phase <= 2'd0;
      cnt   <= 8'd0;
    end else if (mode == 2'd1) begin
      bus_a.i2c_ready <= 1'b0;
      phase <= 2'd0;
    end else if (mode == 2'd2) begin
      bus_a.i2c_ready <= 1'b1;
      phase <= 2'd0;
    end else begin
      case (phase)
        2'd0: begin
          bus_a.i2c_ready <= 1'b1;
          if (bus_a.i2c_start) begin phase <= 2'd1; cnt <= 8'd0; end
        end
        2'd1: begin
          if (cnt == 8'd5) begin bus_a.i2c_ready <= 1'b0; phase <= 2'd2; cnt <= 8'd0; end
          else cnt <= cnt + 8'd1;
        end
        default: begin
          if (cnt == 8'd39) begin bus_a.i2c_ready <= 1'b1; phase <= 2'd0; end
          else cnt <= cnt + 8'd1;
        end
      endcase
    end
  end

  // Scoreboard of issued starts and done assertions
  int         start_count = 0;
  int         done_rises  = 0;
  logic       start_d = 1'b0, done_d = 1'b0, start_b_seen = 1'b0;
  logic [7:0] log_reg [32];
  logic [7:0] log_data[32];
  always @(posedge clk_in) begin
    start_d <= bus_a.i2c_start;
    done_d  <= done_a;
    if (bus_b.i2c_start) start_b_seen <= 1'b1;
    if (bus_a.i2c_start && !start_d) begin
      if (start_count < 32) begin
        log_reg[start_count]  <= bus_a.i2c_reg_addr;
        log_data[start_count] <= bus_a.i2c_data;
      end
      start_count <= start_count + 1;
    end
    if (done_a && !done_d) done_rises <= done_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go_a();
    go_a = 1'b1;
    @(negedge clk_in);
    go_a = 1'b0;
  endtask

  int base, dbase;

  initial begin
    reset_in = 1'b0; go_a = 1'b0; go_b = 1'b0; mode = 2'd0;
    #2 reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_state", cur_state_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_start", bus_a.i2c_start, 0);
    check("rst_index", tbl_index_a, 0);
    check("rst_reg", bus_a.i2c_reg_addr, 0);
    check("rst_data", bus_a.i2c_data, 0);
    check("dev_addr", bus_a.i2c_dev_addr, 7'h1A);
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Full three-entry sequence, with a stray go while busy
    base = start_count; dbase = done_rises;
    pulse_go_a();
    check("go_busy", busy_a, 1);
    check("go_load", cur_state_a, 1);
    check("go_index", tbl_index_a, 0);
    for (int i = 0; i < 300 && cur_state_a != 3'd4; i++) @(negedge clk_in);
    check("reach_wait_done", cur_state_a, 4);
    pulse_go_a();
    for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk_in);
    check("seq_done", done_a, 1);
    check("seq_busy", busy_a, 0);
    check("seq_index", tbl_index_a, 2);
    check("seq_error", error_a, 0);
    check("seq_starts", start_count - base, 3);
    check("e0_reg", log_reg[base], 8'h10);
    check("e0_data", log_data[base], 8'hA5);
    check("e1_reg", log_reg[base+1], 8'h11);
    check("e1_data", log_data[base+1], 8'h5A);
    check("e2_reg", log_reg[base+2], 8'h12);
    check("e2_data", log_data[base+2], 8'hFF);
    repeat (10) @(negedge clk_in);
    check("done_once", done_rises - dbase, 1);

    // Empty table finishes immediately without a start
    go_b = 1'b1;
    @(negedge clk_in);
    go_b = 1'b0;
    check("empty_done", done_b, 1);
    check("empty_state", cur_state_b, 6);
    check("empty_busy", busy_b, 0);
    repeat (5) @(negedge clk_in);
    check("empty_no_start", start_b_seen, 0);

    // Ready stuck low: timeout in WAIT_RDY on entry 0, then a clean restart
    mode = 2'd1;
    repeat (5) @(negedge clk_in);
    pulse_go_a();
    for (int i = 0; i < 300 && !error_a; i++) @(negedge clk_in);
    check("tmo_rdy_error", error_a, 1);
    check("tmo_rdy_state", cur_state_a, 7);
    check("tmo_rdy_start", bus_a.i2c_start, 0);
    check("tmo_rdy_index", tbl_index_a, 0);
    check("tmo_rdy_busy", busy_a, 0);
    mode = 2'd0;
    repeat (5) @(negedge clk_in);
    base = start_count;
    pulse_go_a();
    check("restart_error_clr", error_a, 0);
    for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk_in);
    check("restart_done", done_a, 1);
    check("restart_starts", start_count - base, 3);
    check("restart_e0_reg", log_reg[base], 8'h10);

    // Ready never drops after start: timeout in WAIT_ACCEPT
    mode = 2'd2;
    repeat (5) @(negedge clk_in);
    base = start_count;
    pulse_go_a();
    for (int i = 0; i < 300 && !error_a; i++) @(negedge clk_in);
    check("tmo_acc_error", error_a, 1);
    check("tmo_acc_state", cur_state_a, 7);
    check("tmo_acc_start", bus_a.i2c_start, 0);
    check("tmo_acc_starts", start_count - base, 1);
    mode = 2'd0;
    repeat (5) @(negedge clk_in);

    // Asynchronous reset in WAIT_DONE of entry 1
    pulse_go_a();
    for (int i = 0; i < 500 && !(cur_state_a == 3'd4 && tbl_index_a == 4'd1); i++)
      @(negedge clk_in);
    check("reach_e1_wait_done", {tbl_index_a, 1'b0, cur_state_a}, {4'd1, 1'b0, 3'd4});
    #2 reset_in = 1'b1;
    #1;
    check("arst_state", cur_state_a, 0);
    check("arst_start", bus_a.i2c_start, 0);
    check("arst_index", tbl_index_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_error", error_a, 0);
    check("arst_reg", bus_a.i2c_reg_addr, 0);
    check("arst_data", bus_a.i2c_data, 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    base = start_count;
    pulse_go_a();
    for (int i = 0; i < 300 && start_count == base; i++) @(negedge clk_in);
    check("post_rst_start", start_count - base, 1);
    check("post_rst_reg", log_reg[base], 8'h10);
    check("post_rst_data", log_data[base], 8'hA5);
    for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk_in);
    check("post_rst_done", done_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
